btb_assoc_ctrl: RTL and testbench

- Parametrised N-way set-associative branch target buffer: storage, IF-stage lookup and EX-stage update in one block.
- Per-entry 2-bit saturating direction counters, true-LRU replacement per set, and a multi-cycle flush engine.
- Successor to the fixed 8-set/2-way BTB set-writer: generalised in SETS, WAYS and widths; updates from actual outcome instead of a mispredict flag.

---
 rtl/btb_assoc_ctrl_if.sv | 29 ++
 rtl/btb_assoc_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_btb_assoc_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/btb_assoc_ctrl_if.sv
// Lookup, update and flush signals of the set-associative BTB.
// The master drives requests (fetch/execute side); the slave is the BTB.
interface btb_assoc_ctrl_if #(
    parameter int PC_W  = 32,
    parameter int TGT_W = 32
);
    logic             flush_req;
    logic             flush_busy;
    logic             lu_valid;
    logic [PC_W-1:0]  lu_pc;
    logic             lu_hit;
    logic             lu_taken;
    logic [TGT_W-1:0] lu_target;
    logic             upd_valid;
    logic             upd_ready;
    logic [PC_W-1:0]  upd_pc;
    logic [TGT_W-1:0] upd_target;
    logic             upd_taken;

    modport master (
        output flush_req, lu_valid, lu_pc, upd_valid, upd_pc, upd_target, upd_taken,
        input  flush_busy, lu_hit, lu_taken, lu_target, upd_ready
    );

    modport slave (
        input  flush_req, lu_valid, lu_pc, upd_valid, upd_pc, upd_target, upd_taken,
        output flush_busy, lu_hit, lu_taken, lu_target, upd_ready
    );
endinterface

// File: rtl/btb_assoc_ctrl.sv
// N-way set-associative branch target buffer: storage, registered lookup,
// outcome-driven update with 2-bit direction counters and true-LRU
// replacement, plus a one-set-per-cycle flush engine.
//
// state | meaning
// IDLE  | lookups and updates serviced, flush_req accepted
// FLUSH | clearing set cnt_q; lookups miss, updates stalled
module btb_assoc_ctrl #(
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int PC_W  = 32,
    parameter int TGT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    btb_assoc_ctrl_if.slave    bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = PC_W - IDX_W - 2;
    localparam int AGE_W = $clog2(WAYS);

    typedef enum logic {IDLE, FLUSH} fsm_t;

    fsm_t             fsm_q;
    logic [IDX_W-1:0] cnt_q;
    logic             flush_busy_q;
    logic             lu_hit_q;
    logic             lu_taken_q;
    logic [TGT_W-1:0] lu_target_q;

    logic             valid_q  [SETS][WAYS];
    logic [TAG_W-1:0] tag_q    [SETS][WAYS];
    logic [TGT_W-1:0] target_q [SETS][WAYS];
    logic [1:0]       ctr_q    [SETS][WAYS];
    logic [AGE_W-1:0] age_q    [SETS][WAYS];

    logic [IDX_W-1:0] lu_idx;
    logic [TAG_W-1:0] lu_tag;
    logic             lu_hit_d;
    logic             lu_taken_d;
    logic [TGT_W-1:0] lu_target_d;

    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_acc;
    logic             upd_hit;
    logic [AGE_W-1:0] hit_way;
    logic             inv_found;
    logic [AGE_W-1:0] inv_way;
    logic [AGE_W-1:0] lru_way;
    logic [AGE_W-1:0] upd_way;
    logic [AGE_W-1:0] old_age;
    logic [1:0]       ctr_old;
    logic [1:0]       ctr_new;
    logic [AGE_W-1:0] age_new [WAYS];

    // pc[1:0] never participates in the index or tag
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^{bus.lu_pc[1:0], bus.upd_pc[1:0]};

    assign lu_idx  = bus.lu_pc[IDX_W+1:2];
    assign lu_tag  = bus.lu_pc[PC_W-1:IDX_W+2];
    assign upd_idx = bus.upd_pc[IDX_W+1:2];
    assign upd_tag = bus.upd_pc[PC_W-1:IDX_W+2];

    assign bus.upd_ready  = rst_n && (fsm_q == IDLE);
    assign upd_acc        = bus.upd_valid && bus.upd_ready;
    assign bus.flush_busy = flush_busy_q;
    assign bus.lu_hit     = lu_hit_q;
    assign bus.lu_taken   = lu_taken_q;
    assign bus.lu_target  = lu_target_q;

    // Lookup tag compare against pre-edge storage; forced to miss while flushing
    always_comb begin
        lu_hit_d    = 1'b0;
        lu_taken_d  = 1'b0;
        lu_target_d = '0;
        if (bus.lu_valid && fsm_q == IDLE) begin
            for (int w = 0; w < WAYS; w++) begin
                if (valid_q[lu_idx][w] && tag_q[lu_idx][w] == lu_tag) begin
                    lu_hit_d    = 1'b1;
                    lu_taken_d  = ctr_q[lu_idx][w][1];
                    lu_target_d = target_q[lu_idx][w];
                end
            end
        end
    end

    // Update way selection (hit, else lowest invalid, else oldest), counter and ages
    always_comb begin
        upd_hit   = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        // descending scan so the lowest-index invalid way is the one left in inv_way
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[upd_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = AGE_W'(w);
            end
            if (age_q[upd_idx][w] == AGE_W'(WAYS - 1)) begin
                lru_way = AGE_W'(w);
            end
            if (valid_q[upd_idx][w] && tag_q[upd_idx][w] == upd_tag) begin
                upd_hit = 1'b1;
                hit_way = AGE_W'(w);
            end
        end
        upd_way = upd_hit ? hit_way : (inv_found ? inv_way : lru_way);
        old_age = age_q[upd_idx][upd_way];
        ctr_old = ctr_q[upd_idx][upd_way];

        if (upd_hit) begin
            case (ctr_old)
                2'b00:   ctr_new = bus.upd_taken ? 2'b01 : 2'b00;
                2'b01:   ctr_new = bus.upd_taken ? 2'b11 : 2'b00;
                2'b11:   ctr_new = bus.upd_taken ? 2'b10 : 2'b01;
                default: ctr_new = bus.upd_taken ? 2'b10 : 2'b11;
            endcase
        end else begin
            ctr_new = bus.upd_taken ? 2'b11 : 2'b01;
        end

        for (int w = 0; w < WAYS; w++) begin
            if (AGE_W'(w) == upd_way) begin
                age_new[w] = '0;
            end else if (age_q[upd_idx][w] < old_age) begin
                age_new[w] = age_q[upd_idx][w] + 1'b1;
            end else begin
                age_new[w] = age_q[upd_idx][w];
            end
        end
    end

    // Storage, registered lookup outputs and the flush FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q        <= IDLE;
            cnt_q        <= '0;
            flush_busy_q <= 1'b0;
            lu_hit_q     <= 1'b0;
            lu_taken_q   <= 1'b0;
            lu_target_q  <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w]  <= 1'b0;
                    tag_q[s][w]    <= '0;
                    target_q[s][w] <= '0;
                    ctr_q[s][w]    <= '0;
                    age_q[s][w]    <= AGE_W'(w);
                end
            end
        end else begin
            lu_hit_q    <= lu_hit_d;
            lu_taken_q  <= lu_taken_d;
            lu_target_q <= lu_target_d;

            if (upd_acc) begin
                valid_q[upd_idx][upd_way]  <= 1'b1;
                tag_q[upd_idx][upd_way]    <= upd_tag;
                target_q[upd_idx][upd_way] <= bus.upd_target;
                ctr_q[upd_idx][upd_way]    <= ctr_new;
                for (int w = 0; w < WAYS; w++) begin
                    age_q[upd_idx][w] <= age_new[w];
                end
            end

            case (fsm_q)
                IDLE: begin
                    if (bus.flush_req) begin
                        fsm_q        <= FLUSH;
                        cnt_q        <= '0;
                        flush_busy_q <= 1'b1;
                    end
                end
                FLUSH: begin
                    for (int w = 0; w < WAYS; w++) begin
                        valid_q[cnt_q][w] <= 1'b0;
                        age_q[cnt_q][w]   <= AGE_W'(w);
                    end
                    if (cnt_q == IDX_W'(SETS - 1)) begin
                        fsm_q        <= IDLE;
                        flush_busy_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_btb_assoc_ctrl.sv
// Bench for btb_assoc_ctrl: a recency-timestamp / confidence-level model is
// checked against the DUT every cycle, plus literal checks at key points.
module tb_btb_assoc_ctrl;
    localparam int SETS  = 8;
    localparam int WAYS  = 2;
    localparam int PC_W  = 32;
    localparam int TGT_W = 32;
    localparam int IDX_W = $clog2(SETS);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    btb_assoc_ctrl_if #(.PC_W(PC_W), .TGT_W(TGT_W)) bus ();

    btb_assoc_ctrl #(.SETS(SETS), .WAYS(WAYS), .PC_W(PC_W), .TGT_W(TGT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: entry confidence level 0..3 (taken when >=2), recency via access timestamps
    int          m_valid [SETS][WAYS];
    logic [31:0] m_tag   [SETS][WAYS];
    logic [31:0] m_tgt   [SETS][WAYS];
    int          m_lvl   [SETS][WAYS];
    int          m_last  [SETS][WAYS];
    int          stamp;
    int          flush_left;
    logic        e_hit, e_taken;
    logic [31:0] e_tgt;

    function automatic int sidx(input logic [31:0] pc);
        return int'((pc >> 2) % 32'(SETS));
    endfunction

    function automatic logic [31:0] stag(input logic [31:0] pc);
        return pc >> (IDX_W + 2);
    endfunction

    task automatic m_clear_set(input int s);
        for (int w = 0; w < WAYS; w++) begin
            m_valid[s][w] = 0;
            m_last[s][w]  = -w;
        end
    endtask

    task automatic m_reset();
        for (int s = 0; s < SETS; s++) m_clear_set(s);
        stamp = 0; flush_left = 0;
        e_hit = 0; e_taken = 0; e_tgt = 0;
    endtask

    task automatic m_update(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        int s, hw, v;
        s = sidx(pc); hw = -1; v = -1;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] != 0 && m_tag[s][w] == stag(pc)) hw = w;
        stamp++;
        if (hw >= 0) begin
            m_tgt[s][hw] = tgt;
            if (tk) m_lvl[s][hw] = (m_lvl[s][hw] < 3) ? m_lvl[s][hw] + 1 : 3;
            else    m_lvl[s][hw] = (m_lvl[s][hw] > 0) ? m_lvl[s][hw] - 1 : 0;
            m_last[s][hw] = stamp;
        end else begin
            for (int w = WAYS - 1; w >= 0; w--) if (m_valid[s][w] == 0) v = w;
            if (v < 0) begin
                v = 0;
                for (int w = 1; w < WAYS; w++) if (m_last[s][w] < m_last[s][v]) v = w;
            end
            m_valid[s][v] = 1;
            m_tag[s][v]   = stag(pc);
            m_tgt[s][v]   = tgt;
            m_lvl[s][v]   = tk ? 2 : 1;
            m_last[s][v]  = stamp;
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_reset();
            end else begin
                int  s;
                logic busy;
                busy = (flush_left > 0);
                e_hit = 0; e_taken = 0; e_tgt = 0;
                if (bus.lu_valid && !busy) begin
                    s = sidx(bus.lu_pc);
                    for (int w = 0; w < WAYS; w++)
                        if (m_valid[s][w] != 0 && m_tag[s][w] == stag(bus.lu_pc)) begin
                            e_hit = 1; e_taken = (m_lvl[s][w] >= 2); e_tgt = m_tgt[s][w];
                        end
                end
                if (bus.upd_valid && !busy) m_update(bus.upd_pc, bus.upd_target, bus.upd_taken);
                if (busy) begin
                    m_clear_set(SETS - flush_left);
                    flush_left--;
                end else if (bus.flush_req) begin
                    flush_left = SETS;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            chk("cyc_hit",   bus.lu_hit,     e_hit);
            chk("cyc_taken", bus.lu_taken,   e_taken);
            chk("cyc_tgt",   bus.lu_target,  e_tgt);
            chk("cyc_busy",  bus.flush_busy, flush_left > 0);
            chk("cyc_ready", bus.upd_ready,  rst_n && flush_left == 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        bus.upd_valid = 1; bus.upd_pc = pc; bus.upd_target = tgt; bus.upd_taken = tk;
        step();
        bus.upd_valid = 0;
    endtask

    task automatic look(input logic [31:0] pc);
        bus.lu_valid = 1; bus.lu_pc = pc;
        step();
        bus.lu_valid = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        bus.flush_req = 0; bus.lu_valid = 0; bus.lu_pc = 0;
        bus.upd_valid = 0; bus.upd_pc = 0; bus.upd_target = 0; bus.upd_taken = 0;
        repeat (2) step();
        rst_n = 1; #1;
        chk("ready_after_reset", bus.upd_ready, 1);
        #1;

        look(32'h40);
        chk("reset_miss_hit", bus.lu_hit, 0);
        chk("reset_miss_tgt", bus.lu_target, 0);

        upd(32'h40, 32'h100, 1);
        look(32'h40);
        chk("a_hit", bus.lu_hit, 1);
        chk("a_taken", bus.lu_taken, 1);
        chk("a_tgt", bus.lu_target, 32'h100);
        look(32'h44);
        chk("miss_44", bus.lu_hit, 0);

        upd(32'h40, 32'h100, 0); look(32'h40);
        chk("nt1_taken", bus.lu_taken, 0);
        chk("nt1_hit", bus.lu_hit, 1);
        upd(32'h40, 32'h100, 0);
        upd(32'h40, 32'h100, 0); look(32'h40);
        chk("nt3_taken", bus.lu_taken, 0);
        upd(32'h40, 32'h100, 1); look(32'h40);
        chk("sat_t1_taken", bus.lu_taken, 0);
        upd(32'h40, 32'h100, 1); look(32'h40);
        chk("sat_t2_taken", bus.lu_taken, 1);

        // lookup and insert of the same entry in one cycle: no bypass
        bus.lu_valid = 1; bus.lu_pc = 32'h48;
        upd(32'h48, 32'h555, 0);
        bus.lu_valid = 0;
        chk("nobypass_hit", bus.lu_hit, 0);
        look(32'h4A);
        chk("ignored_lsb_hit", bus.lu_hit, 1);
        chk("ignored_lsb_tgt", bus.lu_target, 32'h555);

        upd(32'h240, 32'h200, 1);
        upd(32'h40, 32'h100, 1);
        upd(32'h440, 32'h300, 0);
        look(32'h40);  chk("lru_a_tgt", bus.lu_target, 32'h100);
        look(32'h440); chk("lru_c_hit", bus.lu_hit, 1);
        chk("lru_c_tgt", bus.lu_target, 32'h300);
        look(32'h240); chk("lru_b_miss", bus.lu_hit, 0);

        bus.flush_req = 1; step(); bus.flush_req = 0;
        cnt = 0;
        while (bus.flush_busy && cnt < 20) begin
            cnt++;
            chk("ready_in_flush", bus.upd_ready, 0);
            bus.flush_req = (cnt == 3);
            bus.lu_valid = 1; bus.lu_pc = 32'h440;
            bus.upd_valid = 1; bus.upd_pc = 32'h80; bus.upd_target = 32'h999; bus.upd_taken = 1;
            step();
        end
        bus.flush_req = 0; bus.lu_valid = 0; bus.upd_valid = 0;
        chk("flush_len", cnt, SETS);
        look(32'h40);  chk("post_flush_a", bus.lu_hit, 0);
        look(32'h440); chk("post_flush_c", bus.lu_hit, 0);
        look(32'h80);  chk("post_flush_stalled_upd", bus.lu_hit, 0);

        upd(32'h40, 32'h111, 1);
        bus.upd_valid = 1; bus.upd_pc = 32'h60; bus.upd_target = 32'h222; bus.upd_taken = 1;
        bus.flush_req = 1;
        step();
        bus.upd_valid = 0; bus.flush_req = 0;
        chk("flush_started", bus.flush_busy, 1);
        step(); step();
        rst_n = 0; #1;
        chk("rst_busy", bus.flush_busy, 0);
        chk("rst_hit", bus.lu_hit, 0);
        chk("rst_tgt", bus.lu_target, 0);
        chk("rst_ready", bus.upd_ready, 0);
        step(); step();
        rst_n = 1;
        look(32'h40); chk("after_rst_a", bus.lu_hit, 0);
        look(32'h60); chk("after_rst_60", bus.lu_hit, 0);
        upd(32'h60, 32'h222, 1); look(32'h60);
        chk("after_rst_insert", bus.lu_target, 32'h222);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
